// File: rtl/vec_mag_pkg.sv
// Shared types and constants for the vector-magnitude pipeline.
package vec_mag_pkg;

  // Input interpretation, sampled with each accepted beat.
  typedef enum logic {
    MODE_TWO_POINT = 1'b0,
    MODE_RADIUS    = 1'b1
  } mode_e;

  // Default coefficients: alpha ~ 1.0, beta ~ 0.375 with 5 fraction bits.
  localparam int unsigned DEF_COORD_WIDTH = 8;
  localparam int unsigned DEF_COEFF_WIDTH = 8;
  localparam int unsigned DEF_ALPHA       = 32;
  localparam int unsigned DEF_BETA        = 12;
  localparam int unsigned DEF_FRAC_BITS   = 5;

  // Output magnitude width: one bit for the difference, one for the estimate gain.
  function automatic int unsigned mag_width(input int unsigned coord_width);
    return coord_width + 2;
  endfunction

endpackage

// File: rtl/vec_mag_stage_reg.sv
// One pipeline slice: valid, data and tlast registers with enable and sync clear.
module vec_mag_stage_reg
  import vec_mag_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  // Clear wins over enable; a disabled slice holds its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/vec_mag_pipe.sv
// Four-stage AXI-Stream alpha-max-beta-min magnitude estimator.
// Optional build macro VEC_MAG_ROUND_EN selects round-half-up instead of truncation.
module vec_mag_pipe
  import vec_mag_pkg::*;
#(
  parameter int unsigned COORD_WIDTH  = DEF_COORD_WIDTH,
  parameter int unsigned COEFF_WIDTH  = DEF_COEFF_WIDTH,
  parameter int unsigned ALPHA        = DEF_ALPHA,
  parameter int unsigned BETA         = DEF_BETA,
  parameter int unsigned FRAC_BITS    = DEF_FRAC_BITS,
  localparam int unsigned MAG_WIDTH   = mag_width(COORD_WIDTH)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [4*COORD_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [MAG_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     core_reset_i,
  input  logic                     core_mode_i,
  output logic                     core_busy_o,
  output logic [31:0]              core_data_processed_cnt_o,
  output logic                     core_sat_o
);

  localparam int unsigned DW    = COORD_WIDTH + 1;
  localparam int unsigned ACC_W = COORD_WIDTH + COEFF_WIDTH + 3;
  // One spare bit so the rounding constant can never wrap the sum.
  localparam int unsigned SUM_W = ACC_W + 1;
`ifdef VEC_MAG_ROUND_EN
  localparam int unsigned RND   = (FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0;
`else
  localparam int unsigned RND   = 0;
`endif
  localparam logic [COEFF_WIDTH-1:0] ALPHA_C = COEFF_WIDTH'(ALPHA);
  localparam logic [COEFF_WIDTH-1:0] BETA_C  = COEFF_WIDTH'(BETA);

  logic en;
  logic clr;

  logic          s1_valid, s2_valid, s3_valid, s4_valid;
  logic          s1_last, s2_last, s3_last, s4_last;
  logic [2*DW-1:0] s1_data, s2_data, s3_data;
  logic [MAG_WIDTH-1:0] s4_data;

  logic signed [COORD_WIDTH-1:0] x1, y1, x2, y2;
  logic signed [DW-1:0]          dx_c, dy_c;
  logic [DW-1:0]                 s1_dx, s1_dy, adx_c, ady_c;
  logic [DW-1:0]                 s2_adx, s2_ady, max_c, min_c;
  logic [DW-1:0]                 s3_max, s3_min;
  logic [ACC_W-1:0]              acc_c;
  logic [SUM_W-1:0]              sum_c, shifted_c;
  logic                          sat_c;
  logic [MAG_WIDTH-1:0]          result_c;

  logic [31:0] cnt;
  logic        sat_flag;

  // Whole pipeline advances unless the output beat is stalled.
  assign en            = m_axis_tready || !m_axis_tvalid;
  assign clr           = core_reset_i;
  assign s_axis_tready = en;

  assign x1 = s_axis_tdata[4*COORD_WIDTH-1 -: COORD_WIDTH];
  assign y1 = s_axis_tdata[3*COORD_WIDTH-1 -: COORD_WIDTH];
  assign x2 = s_axis_tdata[2*COORD_WIDTH-1 -: COORD_WIDTH];
  assign y2 = s_axis_tdata[COORD_WIDTH-1 -: COORD_WIDTH];

  // Stage 1 input: signed differences one bit wider than the coordinates.
  always_comb begin
    dx_c = DW'(x2);
    dy_c = DW'(y2);
    if (mode_e'(core_mode_i) == MODE_TWO_POINT) begin
      dx_c = DW'(x1) - DW'(x2);
      dy_c = DW'(y1) - DW'(y2);
    end
  end

  vec_mag_stage_reg #(.WIDTH(2*DW)) u_s1 (
    .clk       (aclk),
    .rst_n     (aresetn),
    .en        (en),
    .clr       (clr),
    .in_valid  (s_axis_tvalid),
    .in_data   ({dx_c, dy_c}),
    .in_last   (s_axis_tlast),
    .out_valid (s1_valid),
    .out_data  (s1_data),
    .out_last  (s1_last)
  );

  assign s1_dx = s1_data[2*DW-1:DW];
  assign s1_dy = s1_data[DW-1:0];

  // Stage 2 input: magnitudes; -2^COORD_WIDTH still fits as unsigned DW bits.
  always_comb begin
    adx_c = s1_dx[DW-1] ? (~s1_dx + DW'(1)) : s1_dx;
    ady_c = s1_dy[DW-1] ? (~s1_dy + DW'(1)) : s1_dy;
  end

  vec_mag_stage_reg #(.WIDTH(2*DW)) u_s2 (
    .clk       (aclk),
    .rst_n     (aresetn),
    .en        (en),
    .clr       (clr),
    .in_valid  (s1_valid),
    .in_data   ({adx_c, ady_c}),
    .in_last   (s1_last),
    .out_valid (s2_valid),
    .out_data  (s2_data),
    .out_last  (s2_last)
  );

  assign s2_adx = s2_data[2*DW-1:DW];
  assign s2_ady = s2_data[DW-1:0];

  // Stage 3 input: max/min ordering, ties take |dx| as the max.
  always_comb begin
    max_c = s2_ady;
    min_c = s2_adx;
    if (s2_adx >= s2_ady) begin
      max_c = s2_adx;
      min_c = s2_ady;
    end
  end

  vec_mag_stage_reg #(.WIDTH(2*DW)) u_s3 (
    .clk       (aclk),
    .rst_n     (aresetn),
    .en        (en),
    .clr       (clr),
    .in_valid  (s2_valid),
    .in_data   ({max_c, min_c}),
    .in_last   (s2_last),
    .out_valid (s3_valid),
    .out_data  (s3_data),
    .out_last  (s3_last)
  );

  assign s3_max = s3_data[2*DW-1:DW];
  assign s3_min = s3_data[DW-1:0];

  // Stage 4 input: weighted sum, optional rounding, scale and saturate.
  always_comb begin
    acc_c     = ACC_W'(ALPHA_C) * ACC_W'(s3_max) + ACC_W'(BETA_C) * ACC_W'(s3_min);
    sum_c     = SUM_W'(acc_c) + SUM_W'(RND);
    shifted_c = sum_c >> FRAC_BITS;
    sat_c     = |shifted_c[SUM_W-1:MAG_WIDTH];
    result_c  = sat_c ? '1 : shifted_c[MAG_WIDTH-1:0];
  end

  vec_mag_stage_reg #(.WIDTH(MAG_WIDTH)) u_s4 (
    .clk       (aclk),
    .rst_n     (aresetn),
    .en        (en),
    .clr       (clr),
    .in_valid  (s3_valid),
    .in_data   (result_c),
    .in_last   (s3_last),
    .out_valid (s4_valid),
    .out_data  (s4_data),
    .out_last  (s4_last)
  );

  // Count completed output handshakes; wraps naturally at 32 bits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Sticky saturation flag, set when a saturated result enters the output stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_flag <= 1'b0;
    end else if (clr) begin
      sat_flag <= 1'b0;
    end else if (en && s3_valid && sat_c) begin
      sat_flag <= 1'b1;
    end
  end

  assign m_axis_tdata              = s4_data;
  assign m_axis_tvalid             = s4_valid;
  assign m_axis_tlast              = s4_last;
  assign core_busy_o               = s1_valid | s2_valid | s3_valid | s4_valid;
  assign core_data_processed_cnt_o = cnt;
  assign core_sat_o                = sat_flag;

endmodule

// File: tb/tb_vec_mag_pipe.sv
// Self-checking bench for vec_mag_pipe: scoreboard of expected beats vs observed handshakes.
module tb_vec_mag_pipe;

  localparam int unsigned CW = 8;
  localparam int unsigned MW = 10;

`ifdef VEC_MAG_ROUND_EN
  localparam logic [MW-1:0] EXTREME_EXP = 10'd351;
  localparam logic [MW-1:0] SAT_SMALL_EXP = 10'd8;
`else
  localparam logic [MW-1:0] EXTREME_EXP = 10'd350;
  localparam logic [MW-1:0] SAT_SMALL_EXP = 10'd7;
`endif

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          aresetn;
  logic [4*CW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [MW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic          core_reset, core_mode, busy, sat;
  logic [31:0]   cnt;

  logic [4*CW-1:0] z_s_tdata;
  logic          z_s_tvalid, z_s_tready, z_core_reset;
  logic [MW-1:0] z_m_tdata;
  logic          z_m_tvalid, z_m_tlast, z_busy, z_sat;
  logic [31:0]   z_cnt;

  int checks = 0;
  int errors = 0;
  int sent_since_clear = 0;
  logic [MW:0] exp_q[$];
  logic [MW:0] got_q[$];

  vec_mag_pipe dut (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .s_axis_tdata              (s_tdata),
    .s_axis_tvalid             (s_tvalid),
    .s_axis_tlast              (s_tlast),
    .s_axis_tready             (s_tready),
    .m_axis_tdata              (m_tdata),
    .m_axis_tvalid             (m_tvalid),
    .m_axis_tlast              (m_tlast),
    .m_axis_tready             (m_tready),
    .core_reset_i              (core_reset),
    .core_mode_i               (core_mode),
    .core_busy_o               (busy),
    .core_data_processed_cnt_o (cnt),
    .core_sat_o                (sat)
  );

  vec_mag_pipe #(.ALPHA(255), .BETA(0)) dut_sat (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .s_axis_tdata              (z_s_tdata),
    .s_axis_tvalid             (z_s_tvalid),
    .s_axis_tlast              (1'b0),
    .s_axis_tready             (z_s_tready),
    .m_axis_tdata              (z_m_tdata),
    .m_axis_tvalid             (z_m_tvalid),
    .m_axis_tlast              (z_m_tlast),
    .m_axis_tready             (1'b1),
    .core_reset_i              (z_core_reset),
    .core_mode_i               (1'b0),
    .core_busy_o               (z_busy),
    .core_data_processed_cnt_o (z_cnt),
    .core_sat_o                (z_sat)
  );

  // Record every output handshake; inputs only change just after posedge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
  end

  // Reference alpha-max-beta-min estimate for the default parameters.
  function automatic logic [MW-1:0] model(input logic signed [CW-1:0] x1, y1, x2, y2,
                                          input logic mode);
    int dx, dy, mx, mn, acc, r;
    if (mode) begin
      dx = int'(x2);
      dy = int'(y2);
    end else begin
      dx = int'(x1) - int'(x2);
      dy = int'(y1) - int'(y2);
    end
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    mx = (dx >= dy) ? dx : dy;
    mn = (dx >= dy) ? dy : dx;
    acc = 32 * mx + 12 * mn;
`ifdef VEC_MAG_ROUND_EN
    acc = acc + 16;
`endif
    r = acc / 32;
    if (r > 1023) r = 1023;
    return MW'(r);
  endfunction

  // Drive one beat until accepted; optionally log its expected output.
  task automatic send(input logic [CW-1:0] x1, y1, x2, y2, input logic mode, input logic last,
                      input logic [MW-1:0] exp, input bit track);
    bit accepted = 1'b0;
    s_tdata   = {x1, y1, x2, y2};
    s_tvalid  = 1'b1;
    s_tlast   = last;
    core_mode = mode;
    if (track) begin
      exp_q.push_back({last, exp});
      sent_since_clear++;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      accepted = s_tready;
      @(posedge aclk);
      #1;
      if (accepted) break;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=no_accept want=accept");
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Wait until the pipe is empty and all expected beats have appeared.
  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && got_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    core_reset = 1'b0; core_mode = 1'b0;
    z_s_tdata = '0; z_s_tvalid = 1'b0; z_core_reset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got=%b/%h/%b want=0/000/0", m_tvalid, m_tdata, m_tlast);
    end
    checks++;
    if (busy !== 1'b0 || cnt !== 32'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got=%b/%0d/%b want=0/0/0", busy, cnt, sat);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got=%b want=1", s_tready);
    end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_two_point();
    bit ok;
    logic [MW:0] e, g;
    send(8'd3, 8'd4, 8'd0, 8'd0, 1'b0, 1'b1, 10'd5, 1'b1);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL two_point_early got=%b want=0", m_tvalid);
    end
    @(posedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL two_point_latency got=%b want=1", m_tvalid);
    end
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL two_point_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL two_point_beat got=%h want=%h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (cnt !== 32'(sent_since_clear)) begin
      errors++;
      $display("FAIL two_point_cnt got=%0d want=%0d", cnt, sent_since_clear);
    end
  endtask

  task automatic test_extremes_radius();
    bit ok;
    logic [MW:0] e, g;
    send(8'h80, 8'h80, 8'h7f, 8'h7f, 1'b0, 1'b0, EXTREME_EXP, 1'b1);
    send(8'd99, 8'd99, 8'hfa, 8'd8, 1'b1, 1'b1, 10'd10, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ext_rad_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ext_rad_beat got=%h want=%h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (sat !== 1'b0 || cnt !== 32'(sent_since_clear)) begin
      errors++;
      $display("FAIL ext_rad_status got=%b/%0d want=0/%0d", sat, cnt, sent_since_clear);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [MW:0] e, g;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [CW-1:0] a, b, c, d;
          logic md;
          a = CW'($urandom); b = CW'($urandom); c = CW'($urandom); d = CW'($urandom);
          md = 1'($urandom_range(0, 1));
          send(a, b, c, d, md, (k == 9), model(a, b, c, d, md), 1'b1);
        end
      end
      begin
        for (int c = 0; c < 16; c++) begin
          m_tready = !(c >= 3 && c <= 12);
          @(posedge aclk);
          #1;
        end
        m_tready = 1'b1;
      end
      begin
        logic [MW:0] prev = '0;
        bit stalled = 1'b0;
        for (int c = 0; c < 40; c++) begin
          @(negedge aclk);
          if (stalled) begin
            checks++;
            if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev) begin
              errors++;
              $display("FAIL bp_stable got=%b/%h want=1/%h", m_tvalid, {m_tlast, m_tdata}, prev);
            end
          end
          if (m_tvalid && !m_tready) begin
            checks++;
            if (s_tready !== 1'b0) begin
              errors++;
              $display("FAIL bp_tready got=%b want=0", s_tready);
            end
          end
          stalled = m_tvalid && !m_tready;
          prev = {m_tlast, m_tdata};
        end
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_beat got=%h want=%h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (cnt !== 32'(sent_since_clear)) begin
      errors++;
      $display("FAIL bp_cnt got=%0d want=%0d", cnt, sent_since_clear);
    end
  endtask

  task automatic test_saturation();
    bit seen;
    checks++;
    if (z_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_initial got=%b want=0", z_sat);
    end
    z_s_tdata  = {8'd127, 8'd0, 8'h80, 8'd0};
    z_s_tvalid = 1'b1;
    @(posedge aclk); #1;
    z_s_tvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (z_m_tvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (!seen || z_m_tdata !== 10'd1023 || z_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_clip got=%b/%0d/%b want=1/1023/1", seen, z_m_tdata, z_sat);
    end
    @(posedge aclk); #1;
    z_s_tdata  = {8'd1, 8'd0, 8'd0, 8'd0};
    z_s_tvalid = 1'b1;
    @(posedge aclk); #1;
    z_s_tvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (z_m_tvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    checks++;
    if (!seen || z_m_tdata !== SAT_SMALL_EXP || z_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got=%b/%0d/%b want=1/%0d/1", seen, z_m_tdata, z_sat,
               SAT_SMALL_EXP);
    end
    z_core_reset = 1'b1;
    @(posedge aclk); #1;
    z_core_reset = 1'b0;
    checks++;
    if (z_sat !== 1'b0 || z_cnt !== 32'd0) begin
      errors++;
      $display("FAIL sat_clear got=%b/%0d want=0/0", z_sat, z_cnt);
    end
  endtask

  task automatic test_clear();
    bit ok;
    logic [MW:0] e, g;
    m_tready = 1'b1;
    send(8'd10, 8'd20, 8'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    send(8'd30, 8'd40, 8'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    send(8'd50, 8'd60, 8'd0, 8'd0, 1'b0, 1'b1, 10'd0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_prefill got=%b want=1", busy);
    end
    core_reset = 1'b1;
    @(posedge aclk); #1;
    core_reset = 1'b0;
    sent_since_clear = 0;
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || cnt !== 32'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL clear_state got=%b/%b/%0d/%b want=0/0/0/0", busy, m_tvalid, cnt, sat);
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL clear_dropped got=%0d want=0", got_q.size());
    end
    got_q.delete();
    send(8'd3, 8'd4, 8'd0, 8'd0, 1'b0, 1'b1, 10'd5, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clear_after_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL clear_after_beat got=%h want=%h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (cnt !== 32'd1) begin
      errors++;
      $display("FAIL clear_after_cnt got=%0d want=1", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_point();
    test_extremes_radius();
    test_backpressure();
    test_saturation();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
